uart_tx_serializer: RTL and testbench

//  Downstream stage of the result-transmit controller: accepts one byte per
//  tx_start/tx_busy handshake and shifts it onto the UART line as 8N1
//  (start, 8 data LSB-first, stop). Drives the board's serial TX pin. Owns
//  its own bit-rate counter; no external baud tick.

---
 rtl/uart_tx_serializer.sv | 137 +++++++++++++
 tb/tb_uart_tx_serializer.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
// 8N1 UART transmitter with its own bit-rate counter; one byte per tx_start/tx_busy handshake.
// Define UART_TX_PARITY_EN to insert an even-parity bit after data bit 7 (8E1 framing).
module uart_tx_serializer #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx
);

  localparam int CPB   = CLK_FREQ / BAUD;
  localparam int CNT_W = (CPB > 1) ? $clog2(CPB) : 1;
  localparam logic [CNT_W-1:0] CYC_LAST = CNT_W'(CPB - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3
  } state_t;
`endif

  state_t           state;
  logic [CNT_W-1:0] cyc;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             bit_end;

`ifdef UART_TX_PARITY_EN
  logic par;

  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction
`endif

  assign bit_end = (cyc == CYC_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      cyc     <= '0;
      bit_idx <= 3'd0;
      shift   <= 8'h00;
      tx      <= 1'b1;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      tx_done <= 1'b0;
      // Bit-period counter runs in every non-idle state and wraps at each boundary
      if (state != S_IDLE)
        cyc <= bit_end ? '0 : cyc + 1'b1;

      case (state)
        S_IDLE: begin
          tx      <= 1'b1;
          tx_busy <= 1'b0;
          cyc     <= '0;
          bit_idx <= 3'd0;
          if (tx_start) begin
            shift   <= tx_data;
`ifdef UART_TX_PARITY_EN
            par     <= even_parity(tx_data);
`endif
            state   <= S_START;
            tx      <= 1'b0;
            tx_busy <= 1'b1;
          end
        end
        S_START: begin
          if (bit_end) begin
            state <= S_DATA;
            tx    <= shift[0];
          end
        end
        S_DATA: begin
          if (bit_end) begin
            if (bit_idx == 3'd7) begin
              bit_idx <= 3'd0;
`ifdef UART_TX_PARITY_EN
              state   <= S_PARITY;
              tx      <= par;
`else
              state   <= S_STOP;
              tx      <= 1'b1;
`endif
            end else begin
              // tx is registered, so it takes the bit that lands in shift[0] after this shift
              bit_idx <= bit_idx + 3'd1;
              shift   <= {1'b0, shift[7:1]};
              tx      <= shift[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (bit_end) begin
            state <= S_STOP;
            tx    <= 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (bit_end) begin
            state   <= S_IDLE;
            tx      <= 1'b1;
            tx_busy <= 1'b0;
            tx_done <= 1'b1;
          end
        end
        default: begin
          state   <= S_IDLE;
          tx      <= 1'b1;
          tx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench for uart_tx_serializer at CPB=10: expected line bits are queued when a byte
// is offered and compared against per-cycle samples of tx/tx_busy/tx_done.
module tb_uart_tx_serializer;

  localparam int CPB = 10;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FL = NB * CPB;

  logic       clk = 1'b0;
  logic       reset;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       tx_done;
  logic       tx;

  logic exp_q[$];
  logic obs_tx   [0:511];
  logic obs_busy [0:511];
  logic obs_done [0:511];
  int   n_vec;
  int   n_err;

  uart_tx_serializer #(
    .CLK_FREQ(1000),
    .BAUD    (100)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .tx_start(tx_start),
    .tx_data (tx_data),
    .tx_busy (tx_busy),
    .tx_done (tx_done),
    .tx      (tx)
  );

  always #5 clk = ~clk;

  task automatic push_frame(input logic [7:0] d);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
    exp_q.push_back(^d);
`endif
    exp_q.push_back(1'b1);
  endtask

  // Samples outputs on n consecutive falling edges; index i is cycle i after the accepting edge.
  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      obs_tx[i]   = tx;
      obs_busy[i] = tx_busy;
      obs_done[i] = tx_done;
    end
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    tx_start = 1'b1;
    tx_data  = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++;
      if ({tx, tx_busy, tx_done} !== 3'b100) begin
        n_err++;
        $display("FAIL reset_hold cyc=%0d got tx/busy/done=%b%b%b want 100", i, tx, tx_busy, tx_done);
      end
    end
    @(posedge clk);
    #1 reset = 1'b0;
    tx_start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_vec++;
      if ({tx, tx_busy, tx_done} !== 3'b100) begin
        n_err++;
        $display("FAIL reset_idle cyc=%0d got tx/busy/done=%b%b%b want 100", i, tx, tx_busy, tx_done);
      end
    end
  endtask

  task automatic test_single();
    int   ndone;
    logic e;
    @(posedge clk);
    #1 tx_start = 1'b1;
    tx_data = 8'hA5;
    push_frame(8'hA5);
    @(posedge clk);
    #1 tx_start = 1'b0;
    tx_data = 8'h5A;
    capture(FL + 3);
    for (int b = 0; b < NB; b++) begin
      e = exp_q.pop_front();
      for (int c = 0; c < CPB; c++) begin
        n_vec++;
        if (obs_tx[b*CPB+c] !== e) begin
          n_err++;
          $display("FAIL single_tx bit=%0d cyc=%0d got %b want %b", b, c, obs_tx[b*CPB+c], e);
        end
      end
    end
    for (int i = 0; i < FL; i++) begin
      n_vec++;
      if ({obs_busy[i], obs_done[i]} !== 2'b10) begin
        n_err++;
        $display("FAIL single_busy cyc=%0d got busy/done=%b%b want 10", i, obs_busy[i], obs_done[i]);
      end
    end
    n_vec++;
    if ({obs_tx[FL], obs_busy[FL], obs_done[FL]} !== 3'b101) begin
      n_err++;
      $display("FAIL single_done got tx/busy/done=%b%b%b want 101", obs_tx[FL], obs_busy[FL], obs_done[FL]);
    end
    ndone = 0;
    for (int i = 0; i < FL + 3; i++) if (obs_done[i] === 1'b1) ndone++;
    n_vec++;
    if (ndone !== 1) begin
      n_err++;
      $display("FAIL single_done_count got %0d want 1", ndone);
    end
  endtask

  task automatic test_back_to_back();
    logic e;
    @(posedge clk);
    #1 tx_start = 1'b1;
    tx_data = 8'h00;
    push_frame(8'h00);
    push_frame(8'hFF);
    @(posedge clk);
    #1 tx_data = 8'hFF;
    fork
      capture(2*FL + 4);
      begin
        repeat (FL + 5) @(posedge clk);
        #1 tx_start = 1'b0;
      end
    join
    for (int f = 0; f < 2; f++) begin
      for (int b = 0; b < NB; b++) begin
        e = exp_q.pop_front();
        for (int c = 0; c < CPB; c++) begin
          n_vec++;
          if ({obs_tx[f*(FL+1)+b*CPB+c], obs_busy[f*(FL+1)+b*CPB+c]} !== {e, 1'b1}) begin
            n_err++;
            $display("FAIL b2b_frame f=%0d bit=%0d cyc=%0d got tx/busy=%b%b want %b1", f, b, c,
                     obs_tx[f*(FL+1)+b*CPB+c], obs_busy[f*(FL+1)+b*CPB+c], e);
          end
        end
      end
      n_vec++;
      if ({obs_tx[f*(FL+1)+FL], obs_busy[f*(FL+1)+FL], obs_done[f*(FL+1)+FL]} !== 3'b101) begin
        n_err++;
        $display("FAIL b2b_gap f=%0d got tx/busy/done=%b%b%b want 101", f, obs_tx[f*(FL+1)+FL],
                 obs_busy[f*(FL+1)+FL], obs_done[f*(FL+1)+FL]);
      end
    end
    for (int i = 2*FL + 2; i < 2*FL + 4; i++) begin
      n_vec++;
      if ({obs_tx[i], obs_busy[i], obs_done[i]} !== 3'b100) begin
        n_err++;
        $display("FAIL b2b_tail cyc=%0d got tx/busy/done=%b%b%b want 100", i, obs_tx[i], obs_busy[i], obs_done[i]);
      end
    end
  endtask

  task automatic test_ignore();
    logic e;
    @(posedge clk);
    #1 tx_start = 1'b1;
    tx_data = 8'hC3;
    push_frame(8'hC3);
    @(posedge clk);
    #1 tx_start = 1'b0;
    fork
      capture(FL + 15);
      begin
        repeat (35) @(posedge clk);
        #1 tx_start = 1'b1;
        tx_data = 8'h3C;
        @(posedge clk);
        #1 tx_start = 1'b0;
      end
    join
    for (int b = 0; b < NB; b++) begin
      e = exp_q.pop_front();
      for (int c = 0; c < CPB; c++) begin
        n_vec++;
        if ({obs_tx[b*CPB+c], obs_busy[b*CPB+c]} !== {e, 1'b1}) begin
          n_err++;
          $display("FAIL ignore_frame bit=%0d cyc=%0d got tx/busy=%b%b want %b1", b, c,
                   obs_tx[b*CPB+c], obs_busy[b*CPB+c], e);
        end
      end
    end
    n_vec++;
    if ({obs_tx[FL], obs_busy[FL], obs_done[FL]} !== 3'b101) begin
      n_err++;
      $display("FAIL ignore_done got tx/busy/done=%b%b%b want 101", obs_tx[FL], obs_busy[FL], obs_done[FL]);
    end
    for (int i = FL + 1; i < FL + 15; i++) begin
      n_vec++;
      if ({obs_tx[i], obs_busy[i], obs_done[i]} !== 3'b100) begin
        n_err++;
        $display("FAIL ignore_idle cyc=%0d got tx/busy/done=%b%b%b want 100", i, obs_tx[i], obs_busy[i], obs_done[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic fb[0:NB-1];
    logic e;
    @(posedge clk);
    #1 tx_start = 1'b1;
    tx_data = 8'h81;
    push_frame(8'h81);
    @(posedge clk);
    #1 tx_start = 1'b0;
    fork
      capture(60);
      begin
        repeat (47) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
      end
    join
    for (int b = 0; b < NB; b++) fb[b] = exp_q.pop_front();
    for (int i = 0; i < 48; i++) begin
      n_vec++;
      if ({obs_tx[i], obs_busy[i], obs_done[i]} !== {fb[i/CPB], 2'b10}) begin
        n_err++;
        $display("FAIL rstmid_prefix cyc=%0d got tx/busy/done=%b%b%b want %b10", i, obs_tx[i],
                 obs_busy[i], obs_done[i], fb[i/CPB]);
      end
    end
    for (int i = 48; i < 60; i++) begin
      n_vec++;
      if ({obs_tx[i], obs_busy[i], obs_done[i]} !== 3'b100) begin
        n_err++;
        $display("FAIL rstmid_abandon cyc=%0d got tx/busy/done=%b%b%b want 100", i, obs_tx[i],
                 obs_busy[i], obs_done[i]);
      end
    end
    @(posedge clk);
    #1 tx_start = 1'b1;
    tx_data = 8'h81;
    push_frame(8'h81);
    @(posedge clk);
    #1 tx_start = 1'b0;
    capture(FL + 2);
    for (int b = 0; b < NB; b++) begin
      e = exp_q.pop_front();
      for (int c = 0; c < CPB; c++) begin
        n_vec++;
        if ({obs_tx[b*CPB+c], obs_busy[b*CPB+c]} !== {e, 1'b1}) begin
          n_err++;
          $display("FAIL rstmid_refr bit=%0d cyc=%0d got tx/busy=%b%b want %b1", b, c,
                   obs_tx[b*CPB+c], obs_busy[b*CPB+c], e);
        end
      end
    end
    n_vec++;
    if ({obs_tx[FL], obs_busy[FL], obs_done[FL]} !== 3'b101) begin
      n_err++;
      $display("FAIL rstmid_refr_done got tx/busy/done=%b%b%b want 101", obs_tx[FL], obs_busy[FL], obs_done[FL]);
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    logic [7:0] bytes[2];
    logic       pbit[2];
    int         nbusy;
    logic       e;
    bytes[0] = 8'h07; pbit[0] = 1'b1;
    bytes[1] = 8'h03; pbit[1] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1 tx_start = 1'b1;
      tx_data = bytes[k];
      push_frame(bytes[k]);
      @(posedge clk);
      #1 tx_start = 1'b0;
      capture(FL + 3);
      for (int b = 0; b < NB; b++) begin
        e = exp_q.pop_front();
        for (int c = 0; c < CPB; c++) begin
          n_vec++;
          if (obs_tx[b*CPB+c] !== e) begin
            n_err++;
            $display("FAIL parity_frame byte=%h bit=%0d cyc=%0d got %b want %b", bytes[k], b, c, obs_tx[b*CPB+c], e);
          end
        end
      end
      n_vec++;
      if (obs_tx[9*CPB+5] !== pbit[k]) begin
        n_err++;
        $display("FAIL parity_bit byte=%h got %b want %b", bytes[k], obs_tx[9*CPB+5], pbit[k]);
      end
      nbusy = 0;
      for (int i = 0; i < FL + 3; i++) if (obs_busy[i] === 1'b1) nbusy++;
      n_vec++;
      if (nbusy !== 110) begin
        n_err++;
        $display("FAIL parity_busy_len byte=%h got %0d want 110", bytes[k], nbusy);
      end
    end
  endtask
`endif

  initial begin
    n_vec    = 0;
    n_err    = 0;
    reset    = 1'b1;
    tx_start = 1'b0;
    tx_data  = 8'h00;
    test_reset();
    test_single();
    test_back_to_back();
    test_ignore();
    test_reset_mid();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
